// File: rtl/serv_decode_pkg.sv
// Shared constants and the packed pre-decoded entry layout for the decode queue.
package serv_decode_pkg;

  localparam logic [4:0] OPC_LOAD    = 5'b00000;
  localparam logic [4:0] OPC_MISCMEM = 5'b00011;
  localparam logic [4:0] OPC_OPIMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC   = 5'b00101;
  localparam logic [4:0] OPC_STORE   = 5'b01000;
  localparam logic [4:0] OPC_OP      = 5'b01100;
  localparam logic [4:0] OPC_LUI     = 5'b01101;
  localparam logic [4:0] OPC_BRANCH  = 5'b11000;
  localparam logic [4:0] OPC_JALR    = 5'b11001;
  localparam logic [4:0] OPC_JAL     = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM  = 5'b11100;

  // Bit positions inside the one-hot opclass vector
  localparam int CLS_LOAD    = 0;
  localparam int CLS_MISCMEM = 1;
  localparam int CLS_OPIMM   = 2;
  localparam int CLS_AUIPC   = 3;
  localparam int CLS_STORE   = 4;
  localparam int CLS_OP      = 5;
  localparam int CLS_LUI     = 6;
  localparam int CLS_BRANCH  = 7;
  localparam int CLS_JALR    = 8;
  localparam int CLS_JAL     = 9;
  localparam int CLS_SYSTEM  = 10;
  localparam int NUM_CLS     = 11;

  localparam logic [NUM_CLS-1:0] RD_OP_MASK =
    (NUM_CLS'(1) << CLS_OPIMM) | (NUM_CLS'(1) << CLS_AUIPC) | (NUM_CLS'(1) << CLS_OP) |
    (NUM_CLS'(1) << CLS_LUI)   | (NUM_CLS'(1) << CLS_SYSTEM) | (NUM_CLS'(1) << CLS_JALR) |
    (NUM_CLS'(1) << CLS_JAL)   | (NUM_CLS'(1) << CLS_LOAD);

  typedef struct packed {
    logic [NUM_CLS-1:0] opclass;
    logic [2:0]         funct3;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic               imm30;
    logic [3:0]         csr_bits;
    logic               cfu_op;
    logic               rd_op;
    logic               two_stage_op;
    logic               illegal;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/serv_predecode.sv
// Combinational pre-decode of one fetched word (bits [31:2]) into a queue entry.
module serv_predecode
  import serv_decode_pkg::*;
#(
  parameter int CFU = 0
) (
  input  logic [29:0] i_wb_rdt,
  output entry_t      o_entry
);

  logic [4:0]         opc;
  logic [2:0]         funct3;
  logic               bit25;
  logic [NUM_CLS-1:0] cls;
  logic               legal;
  logic               cfu_op;
  logic               unused_bits;

  // Instruction bit n lives at i_wb_rdt[n-2]
  assign opc    = i_wb_rdt[4:0];
  assign funct3 = i_wb_rdt[12:10];
  assign bit25  = i_wb_rdt[23];
  assign unused_bits = ^{i_wb_rdt[29], i_wb_rdt[27:25]};

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cls   = '0;
    legal = 1'b1;
    case (opc)
      OPC_LOAD:    cls[CLS_LOAD]    = 1'b1;
      OPC_MISCMEM: cls[CLS_MISCMEM] = 1'b1;
      OPC_OPIMM:   cls[CLS_OPIMM]   = 1'b1;
      OPC_AUIPC:   cls[CLS_AUIPC]   = 1'b1;
      OPC_STORE:   cls[CLS_STORE]   = 1'b1;
      OPC_OP:
        if (bit25 && (CFU == 0)) legal = 1'b0;
        else                     cls[CLS_OP] = 1'b1;
      OPC_LUI:     cls[CLS_LUI]     = 1'b1;
      OPC_BRANCH:  cls[CLS_BRANCH]  = 1'b1;
      OPC_JALR:    cls[CLS_JALR]    = 1'b1;
      OPC_JAL:     cls[CLS_JAL]     = 1'b1;
      OPC_SYSTEM:  cls[CLS_SYSTEM]  = 1'b1;
      default:     legal = 1'b0;
    endcase
  end

  assign cfu_op = (CFU != 0) && cls[CLS_OP] && bit25;

  always_comb begin
    o_entry          = '0;
    o_entry.opclass  = cls;
    o_entry.funct3   = funct3;
    o_entry.rd       = i_wb_rdt[9:5];
    o_entry.rs1      = i_wb_rdt[17:13];
    o_entry.rs2      = i_wb_rdt[22:18];
    o_entry.imm30    = i_wb_rdt[28];
    o_entry.csr_bits = {i_wb_rdt[24], i_wb_rdt[20], i_wb_rdt[19], i_wb_rdt[18]};
    o_entry.cfu_op   = cfu_op;
    o_entry.rd_op    = |(cls & RD_OP_MASK);
    // Memory ops, jumps, branches, shifts and set-less-than need a second pass
    o_entry.two_stage_op = ~opc[2]
                         | (funct3[0] & ~funct3[1] & ~opc[0] & ~opc[4])
                         | (funct3[1] & ~funct3[2] & ~opc[0] & ~opc[4])
                         | cfu_op;
    o_entry.illegal  = ~legal;
  end

endmodule

// File: rtl/serv_decode_queue.sv
// DEPTH-entry queue of pre-decoded instruction words between fetch and state/ctrl.
module serv_decode_queue
  import serv_decode_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int CFU       = 0,
  parameter int AFULL_LVL = 1
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic [29:0]              i_wb_rdt,
  input  logic                     i_wb_en,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_almost_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic [NUM_CLS-1:0]       o_opclass,
  output logic [2:0]               o_funct3,
  output logic [4:0]               o_rd,
  output logic [4:0]               o_rs1,
  output logic [4:0]               o_rs2,
  output logic                     o_imm30,
  output logic [3:0]               o_csr_bits,
  output logic                     o_cfu_op,
  output logic                     o_rd_op,
  output logic                     o_two_stage_op,
  output logic                     o_illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        new_entry;
  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          pop_ok, push_ok, drop;

  serv_predecode #(.CFU(CFU)) u_predecode (
    .i_wb_rdt (i_wb_rdt),
    .o_entry  (new_entry)
  );

  assign o_valid       = (count != '0);
  assign o_full        = (count == CW'(DEPTH));
  assign o_almost_full = (count >= CW'(DEPTH - AFULL_LVL));
  assign o_count       = count;
  assign o_overflow    = overflow;

  // A pop frees the slot a simultaneous push needs, so a full queue still accepts that push
  assign pop_ok  = i_pop & o_valid;
  assign push_ok = i_wb_en & (~o_full | pop_ok);
  assign drop    = i_wb_en & o_full & ~pop_ok;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (i_flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  // NOTE: entry storage has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push_ok && !i_flush) mem[wr_ptr] <= new_entry;
  end

  assign head = o_valid ? mem[rd_ptr] : '0;

  assign o_opclass      = head.opclass;
  assign o_funct3       = head.funct3;
  assign o_rd           = head.rd;
  assign o_rs1          = head.rs1;
  assign o_rs2          = head.rs2;
  assign o_imm30        = head.imm30;
  assign o_csr_bits     = head.csr_bits;
  assign o_cfu_op       = head.cfu_op;
  assign o_rd_op        = head.rd_op;
  assign o_two_stage_op = head.two_stage_op;
  assign o_illegal      = head.illegal;

endmodule

// File: tb/tb_serv_decode_queue.sv
// Directed self-checking bench: DEPTH=4/CFU=0 main instance plus a CFU=1 instance on shared inputs.
module tb_serv_decode_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] rdt;
  logic        en, pop, flush;

  logic        valid, full, afull, ovf, imm30, cfu, rd_op, two, ill;
  logic [2:0]  count, f3;
  logic [10:0] cls;
  logic [4:0]  rd, rs1, rs2;
  logic [3:0]  csr;

  logic        c_valid, c_full, c_afull, c_ovf, c_imm30, c_cfu, c_rd_op, c_two, c_ill;
  logic [1:0]  c_count;
  logic [2:0]  c_f3;
  logic [10:0] c_cls;
  logic [4:0]  c_rd, c_rs1, c_rs2;
  logic [3:0]  c_csr;

  serv_decode_queue #(.DEPTH(4), .CFU(0), .AFULL_LVL(1)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_wb_rdt(rdt), .i_wb_en(en), .i_pop(pop), .i_flush(flush),
    .o_valid(valid), .o_full(full), .o_almost_full(afull), .o_count(count), .o_overflow(ovf),
    .o_opclass(cls), .o_funct3(f3), .o_rd(rd), .o_rs1(rs1), .o_rs2(rs2), .o_imm30(imm30),
    .o_csr_bits(csr), .o_cfu_op(cfu), .o_rd_op(rd_op), .o_two_stage_op(two), .o_illegal(ill)
  );

  serv_decode_queue #(.DEPTH(2), .CFU(1), .AFULL_LVL(1)) dut_c (
    .clk(clk), .i_rst_n(rst_n), .i_wb_rdt(rdt), .i_wb_en(en), .i_pop(pop), .i_flush(flush),
    .o_valid(c_valid), .o_full(c_full), .o_almost_full(c_afull), .o_count(c_count),
    .o_overflow(c_ovf), .o_opclass(c_cls), .o_funct3(c_f3), .o_rd(c_rd), .o_rs1(c_rs1),
    .o_rs2(c_rs2), .o_imm30(c_imm30), .o_csr_bits(c_csr), .o_cfu_op(c_cfu), .o_rd_op(c_rd_op),
    .o_two_stage_op(c_two), .o_illegal(c_ill)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] insn;
    logic [10:0] cls;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        rd_op;
  } vec_t;

  vec_t v[6];

  function automatic logic [37:0] head_all();
    return {cls, f3, rd, rs1, rs2, imm30, csr, cfu, rd_op, two, ill};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] insn, input logic do_push, input logic do_pop,
                       input logic do_flush);
    logic [31:0] w;
    w     = insn;
    rdt   = w[31:2];
    en    = do_push;
    pop   = do_pop;
    flush = do_flush;
    tick();
    en    = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
  endtask

  task automatic check_head(input string tag, input vec_t e);
    check({tag, ".valid"}, 64'(valid), 64'd1);
    check({tag, ".cls"},   64'(cls),   64'(e.cls));
    check({tag, ".rd"},    64'(rd),    64'(e.rd));
    check({tag, ".rs1"},   64'(rs1),   64'(e.rs1));
    check({tag, ".rs2"},   64'(rs2),   64'(e.rs2));
    check({tag, ".f3"},    64'(f3),    64'(e.f3));
    check({tag, ".rd_op"}, 64'(rd_op), 64'(e.rd_op));
    check({tag, ".ill"},   64'(ill),   64'd0);
  endtask

  initial begin
    //        insn          opclass      rd  rs1 rs2 f3 rd_op
    v[0] = '{32'h00500093, 11'h004,     1,  0,  5,  0, 1'b1};  // addi x1,x0,5
    v[1] = '{32'h002081B3, 11'h020,     3,  1,  2,  0, 1'b1};  // add x3,x1,x2
    v[2] = '{32'h123452B7, 11'h040,     5,  8,  3,  5, 1'b1};  // lui x5,0x12345
    v[3] = '{32'h0020A223, 11'h010,     4,  1,  2,  2, 1'b0};  // sw x2,4(x1)
    v[4] = '{32'h00000063, 11'h080,     0,  0,  0,  0, 1'b0};  // beq x0,x0,0
    v[5] = '{32'h000000EF, 11'h200,     1,  0,  0,  0, 1'b1};  // jal x1,0

    rst_n = 1'b0; en = 1'b0; pop = 1'b0; flush = 1'b0; rdt = '0;
    #12 rst_n = 1'b1;
    check("rst.valid", 64'(valid), 64'd0);
    check("rst.count", 64'(count), 64'd0);
    check("rst.full",  64'(full),  64'd0);
    check("rst.afull", 64'(afull), 64'd0);
    check("rst.ovf",   64'(ovf),   64'd0);
    check("rst.head",  64'(head_all()), 64'd0);

    // First push: addi x1,x0,5
    drive(v[0].insn, 1, 0, 0);
    check_head("addi", v[0]);
    check("addi.count", 64'(count), 64'd1);
    check("addi.two",   64'(two),   64'd0);
    check("addi.csr",   64'(csr),   64'h5);
    check("addi.imm30", 64'(imm30), 64'd0);

    // Fill to DEPTH=4
    drive(v[1].insn, 1, 0, 0);
    check("fill2.count", 64'(count), 64'd2);
    check("fill2.afull", 64'(afull), 64'd0);
    drive(v[2].insn, 1, 0, 0);
    check("fill3.count", 64'(count), 64'd3);
    check("fill3.afull", 64'(afull), 64'd1);
    check("fill3.full",  64'(full),  64'd0);
    drive(v[3].insn, 1, 0, 0);
    check("fill4.count", 64'(count), 64'd4);
    check("fill4.full",  64'(full),  64'd1);
    check("fill4.afull", 64'(afull), 64'd1);
    check("fill4.ovf",   64'(ovf),   64'd0);

    // Push while full, no pop: dropped
    drive(v[4].insn, 1, 0, 0);
    check("drop.count", 64'(count), 64'd4);
    check("drop.ovf",   64'(ovf),   64'd1);
    check_head("drop.head", v[0]);

    // Full, push+pop same cycle
    drive(v[5].insn, 1, 1, 0);
    check("pp.count", 64'(count), 64'd4);
    check("pp.full",  64'(full),  64'd1);
    check_head("pp.head", v[1]);

    drive(32'h0, 0, 1, 0);
    check_head("pop.v2", v[2]);
    drive(32'h0, 0, 1, 0);
    check_head("pop.v3", v[3]);
    drive(32'h0, 0, 1, 0);
    check_head("pop.v5", v[5]);
    check("pop.v5.count", 64'(count), 64'd1);
    drive(32'h0, 0, 1, 0);
    check("empty.valid", 64'(valid), 64'd0);
    check("empty.count", 64'(count), 64'd0);
    check("empty.head",  64'(head_all()), 64'd0);
    check("empty.ovf",   64'(ovf),   64'd1);

    // Push+pop while empty: pop ignored
    drive(v[0].insn, 1, 1, 0);
    check("epp.count", 64'(count), 64'd1);
    check_head("epp.head", v[0]);

    // Flush with simultaneous push
    drive(v[1].insn, 1, 0, 0);
    drive(v[2].insn, 1, 0, 0);
    check("preflush.count", 64'(count), 64'd3);
    drive(v[3].insn, 1, 0, 1);
    check("flush.count", 64'(count), 64'd0);
    check("flush.valid", 64'(valid), 64'd0);
    check("flush.ovf",   64'(ovf),   64'd0);
    check("flush.head",  64'(head_all()), 64'd0);
    tick();
    check("postflush.count", 64'(count), 64'd0);

    // custom-0 opcode: illegal
    drive(32'h0000000B, 1, 0, 0);
    check("cust.valid", 64'(valid), 64'd1);
    check("cust.ill",   64'(ill),   64'd1);
    check("cust.cls",   64'(cls),   64'd0);
    check("cust.rd_op", 64'(rd_op), 64'd0);
    check("cust.c_ill", 64'(c_ill), 64'd1);
    drive(32'h0, 0, 1, 0);

    // OP with bit25 set (mul x3,x1,x2)
    drive(32'h022081B3, 1, 0, 0);
    check("mul.ill",     64'(ill),     64'd1);
    check("mul.cls",     64'(cls),     64'd0);
    check("mul.rd_op",   64'(rd_op),   64'd0);
    check("mul.cfu",     64'(cfu),     64'd0);
    check("mul.c_cfu",   64'(c_cfu),   64'd1);
    check("mul.c_two",   64'(c_two),   64'd1);
    check("mul.c_ill",   64'(c_ill),   64'd0);
    check("mul.c_cls",   64'(c_cls),   64'h020);
    check("mul.c_rd_op", 64'(c_rd_op), 64'd1);
    drive(32'h0, 0, 1, 0);
    check("mul.popped", 64'(count), 64'd0);

    // Asynchronous reset mid-stream with 2 entries
    drive(v[0].insn, 1, 0, 0);
    drive(v[1].insn, 1, 0, 0);
    check("arst.pre", 64'(count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst.valid",   64'(valid),   64'd0);
    check("arst.count",   64'(count),   64'd0);
    check("arst.head",    64'(head_all()), 64'd0);
    check("arst.c_valid", 64'(c_valid), 64'd0);
    #3 rst_n = 1'b1;
    drive(v[2].insn, 1, 0, 0);
    check("arst.p1.count", 64'(count), 64'd1);
    check_head("arst.p1", v[2]);
    drive(v[3].insn, 1, 1, 0);
    check("arst.pp.count", 64'(count), 64'd1);
    check_head("arst.pp", v[3]);
    drive(32'h0, 0, 1, 0);
    check("arst.end.valid", 64'(valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
